// File: rtl/seg7_nios2_qsys_oci_dct_packer_pkg.sv
// Shared constants, state encoding and slot helper for the OCI DCT packer.
package seg7_nios2_qsys_oci_dct_pkg;

  localparam int unsigned DCT_SLOTS = 15;
  localparam int unsigned CODE_W    = 2;
  localparam int unsigned DCT_W     = DCT_SLOTS * CODE_W;
  localparam int unsigned CNT_W     = 4;

  typedef enum logic [1:0] {
    RUN,
    ENDING,
    ENDED
  } dct_state_t;

  localparam logic [CODE_W-1:0] DCT_CODE_NONE = 2'b00;

  // Writes a code into slot 'cnt'; a count past the last slot leaves the frame untouched.
  function automatic logic [DCT_W-1:0] slot_insert(input logic [DCT_W-1:0]  acc,
                                                   input logic [CNT_W-1:0]  cnt,
                                                   input logic [CODE_W-1:0] code);
    logic [DCT_W-1:0] r;
    r = acc;
    for (int unsigned k = 0; k < DCT_SLOTS; k++) begin
      if (cnt == CNT_W'(k)) r[k*CODE_W +: CODE_W] = code;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_nios2_qsys_oci_dct_packer_if.sv
// Code-in / frame-out handshake bundle of the OCI DCT packer.
interface seg7_nios2_qsys_oci_dct_packer_if;
  import seg7_nios2_qsys_oci_dct_pkg::*;

  logic                code_valid;
  logic [CODE_W-1:0]   code;
  logic                code_ready;
  logic                flush;
  logic                test_end_req;
  logic                frame_valid;
  logic                frame_ready;
  logic [DCT_W-1:0]    dct_buffer;
  logic [CNT_W-1:0]    dct_count;
  logic                test_ending;
  logic                test_has_ended;

  modport master (
    output code_valid, code, flush, test_end_req, frame_ready,
    input  code_ready, frame_valid, dct_buffer, dct_count, test_ending, test_has_ended
  );

  modport slave (
    input  code_valid, code, flush, test_end_req, frame_ready,
    output code_ready, frame_valid, dct_buffer, dct_count, test_ending, test_has_ended
  );
endinterface

// File: rtl/seg7_nios2_qsys_oci_dct_packer_frame_reg.sv
// Output frame holding register: loads a packed frame, holds it until taken.
module seg7_nios2_qsys_oci_dct_frame_reg
  import seg7_nios2_qsys_oci_dct_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [DCT_W-1:0] i_load_buf,
  input  logic [CNT_W-1:0] i_load_cnt,
  input  logic             i_frame_ready,
  output logic             o_frame_valid,
  output logic [DCT_W-1:0] o_dct_buffer,
  output logic [CNT_W-1:0] o_dct_count
);

  logic             r_valid;
  logic [DCT_W-1:0] r_buf;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_buf   <= '0;
      r_cnt   <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_buf   <= i_load_buf;
      r_cnt   <= i_load_cnt;
    end else if (i_frame_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_frame_valid = r_valid;
  assign o_dct_buffer  = r_buf;
  assign o_dct_count   = r_cnt;

endmodule

// File: rtl/seg7_nios2_qsys_oci_dct_packer.sv
// Packs 2-bit DCT trace codes into 30-bit frames with drain/finish control.
// Optional SEG7_OCI_DCT_STALL_CNT_EN adds a saturating stall_cnt output.
module seg7_nios2_qsys_oci_dct_packer
  import seg7_nios2_qsys_oci_dct_pkg::*;
(
  input  logic clk,
  input  logic reset,
  seg7_nios2_qsys_oci_dct_packer_if.slave bus
`ifdef SEG7_OCI_DCT_STALL_CNT_EN
  ,
  output logic [7:0] stall_cnt
`endif
);

  dct_state_t       r_state;
  logic [DCT_W-1:0] r_acc;
  logic [CNT_W-1:0] r_acc_cnt;
  logic             r_flush_pend;
  logic             r_test_ending;
  logic             r_test_has_ended;

  logic             w_code_ready;
  logic             w_accept;
  logic             w_store;
  logic             w_flush_eff;
  logic [DCT_W-1:0] w_acc_next;
  logic [CNT_W-1:0] w_acc_cnt_next;
  logic             w_xfer;
  logic             w_out_free;
  logic             w_load;
  logic             w_frame_valid;
  logic [DCT_W-1:0] w_dct_buffer;
  logic [CNT_W-1:0] w_dct_count;

  assign w_code_ready = (r_state == RUN) && (r_acc_cnt != CNT_W'(DCT_SLOTS));

  always_comb begin
    w_accept       = bus.code_valid & w_code_ready;
    w_store        = w_accept && (bus.code != DCT_CODE_NONE);
    w_acc_next     = w_store ? slot_insert(r_acc, r_acc_cnt, bus.code) : r_acc;
    w_acc_cnt_next = r_acc_cnt + CNT_W'(w_store);
    w_flush_eff    = bus.flush | r_flush_pend;
    w_xfer         = (w_acc_cnt_next == CNT_W'(DCT_SLOTS)) ||
                     ((w_flush_eff || (r_state == ENDING)) && (w_acc_cnt_next != '0));
    w_out_free     = !w_frame_valid || bus.frame_ready;
    w_load         = w_xfer & w_out_free;
  end

  // A stalled transfer keeps the grown accumulator; flush intent survives until it loads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc        <= '0;
      r_acc_cnt    <= '0;
      r_flush_pend <= 1'b0;
    end else if (w_load) begin
      r_acc        <= '0;
      r_acc_cnt    <= '0;
      r_flush_pend <= 1'b0;
    end else begin
      r_acc        <= w_acc_next;
      r_acc_cnt    <= w_acc_cnt_next;
      r_flush_pend <= w_flush_eff & w_xfer;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state          <= RUN;
      r_test_ending    <= 1'b0;
      r_test_has_ended <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (bus.test_end_req) begin
            r_state       <= ENDING;
            r_test_ending <= 1'b1;
          end
        end
        ENDING: begin
          if ((r_acc_cnt == '0) && (!w_frame_valid || bus.frame_ready)) begin
            r_state          <= ENDED;
            r_test_ending    <= 1'b0;
            r_test_has_ended <= 1'b1;
          end
        end
        default: begin
          r_state <= ENDED;
        end
      endcase
    end
  end

  seg7_nios2_qsys_oci_dct_frame_reg u_frame_reg (
    .clk           (clk),
    .reset         (reset),
    .i_load        (w_load),
    .i_load_buf    (w_acc_next),
    .i_load_cnt    (w_acc_cnt_next),
    .i_frame_ready (bus.frame_ready),
    .o_frame_valid (w_frame_valid),
    .o_dct_buffer  (w_dct_buffer),
    .o_dct_count   (w_dct_count)
  );

  assign bus.code_ready     = w_code_ready;
  assign bus.frame_valid    = w_frame_valid;
  assign bus.dct_buffer     = w_dct_buffer;
  assign bus.dct_count      = w_dct_count;
  assign bus.test_ending    = r_test_ending;
  assign bus.test_has_ended = r_test_has_ended;

`ifdef SEG7_OCI_DCT_STALL_CNT_EN
  logic [7:0] r_stall_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if ((r_state == RUN) && bus.code_valid && !w_code_ready &&
                 (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 8'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule
